// File: rtl/gray_pkg.sv
// gray_pkg: shared Gray/binary conversion helpers for the Gray-code counter
//   bin2gray(b)  : binary -> Gray on a MAXW-bit word (zero-extend narrower values)
//   gray2bin(g)  : Gray -> binary on a MAXW-bit word (upper zero bits stay zero)
//   max_count(n) : 2^n - 1, the top of an n-bit count range
package gray_pkg;
   localparam int MAXW = 32;
   typedef logic [MAXW-1:0] word_t;
   function automatic word_t bin2gray(input word_t b);
      return b ^ (b >> 1);
   endfunction
   // Prefix XOR from the MSB down, done in log2(MAXW) shift stages.
   function automatic word_t gray2bin(input word_t g);
      word_t b;
      b = g;
      for (int s = 1; s < MAXW; s = s * 2) b = b ^ (b >> s);
      return b;
   endfunction
   function automatic word_t max_count(input int n);
      return (word_t'(1) << n) - word_t'(1);
   endfunction
endpackage

// File: rtl/gray_checker.sv
// gray_checker: sticky consistency monitor for the Gray counter outputs
//   clk, rst : clock, synchronous active-high reset (clears err)
//   load     : counter load strobe, marks the next gray change as arbitrary
//   gray, bin: registered counter outputs being monitored
//   err      : sticky flag, set one cycle after a mismatch or a multi-bit gray step
module gray_checker
   import gray_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [N-1:0] gray,
   input  logic [N-1:0] bin,
   output logic         err
);
   logic [N-1:0] r_prev;
   logic         r_fresh;
   logic         r_err;
   logic         w_bad;
   // r_fresh is set when the edge that produced the current gray was a load or
   // reset, so that jump is not treated as a multi-bit step.
   always_comb begin
      w_bad = (N'(gray2bin(word_t'(gray))) != bin) ||
              (!r_fresh && ($countones(gray ^ r_prev) > 1));
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_prev  <= '0;
         r_fresh <= 1'b1;
         r_err   <= 1'b0;
      end else begin
         r_prev  <= gray;
         r_fresh <= load;
         r_err   <= r_err | w_bad;
      end
   end
   assign err = r_err;
endmodule

// File: rtl/gray_updn_counter.sv
// gray_updn_counter: up/down Gray counter with load, wrap/saturate and terminal-count pulse
//   clk, rst : clock, synchronous active-high reset
//   en, up   : count enable and direction (1 = increment)
//   load     : synchronous load of load_val (binary), overrides en
//   bin, gray: registered binary and Gray count, updated on the same edge
//   tc       : one-cycle pulse when a counting step starts from a bound
//   err      : sticky checker flag, only when GRAY_CHECK_EN is defined
module gray_updn_counter
   import gray_pkg::*;
#(
   parameter int N   = 4,
   parameter bit SAT = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         up,
   input  logic         load,
   input  logic [N-1:0] load_val,
   output logic [N-1:0] bin,
   output logic [N-1:0] gray,
   output logic         tc
`ifdef GRAY_CHECK_EN
   ,
   output logic         err
`endif
);
   localparam logic [N-1:0] MAX = N'(max_count(N));
   logic [N-1:0] r_bin, r_gray, w_step, w_nbin, w_ngray;
   logic         r_tc, w_bound;
   // Gray is derived from the next binary value so both flops load together.
   always_comb begin
      w_bound = up ? (r_bin == MAX) : (r_bin == '0);
      w_step  = up ? r_bin + N'(1) : r_bin - N'(1);
      w_nbin  = load ? load_val : !en ? r_bin : (SAT && w_bound) ? r_bin : w_step;
      w_ngray = N'(bin2gray(word_t'(w_nbin)));
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_bin  <= '0;
         r_gray <= '0;
         r_tc   <= 1'b0;
      end else begin
         r_bin  <= w_nbin;
         r_gray <= w_ngray;
         r_tc   <= !load && en && w_bound;
      end
   end
   assign bin  = r_bin;
   assign gray = r_gray;
   assign tc   = r_tc;
`ifdef GRAY_CHECK_EN
   gray_checker #(.N(N)) u_chk (
      .clk (clk),
      .rst (rst),
      .load(load),
      .gray(r_gray),
      .bin (r_bin),
      .err (err)
   );
`endif
endmodule

// File: tb/tb_gray_updn_counter.sv
// tb_gray_updn_counter: directed self-checking bench for gray_updn_counter (wrap and saturate builds)
module tb_gray_updn_counter;
   logic       clk = 1'b0;
   logic       rst = 1'b0, en = 1'b0, up = 1'b1, load = 1'b0;
   logic [3:0] load_val = '0;
   logic [3:0] bin0, gray0, bin1, gray1, prev;
   logic       tc0, tc1;
   int         n_checks = 0, n_errors = 0;
`ifdef GRAY_CHECK_EN
   logic       err0, err1;
`endif

   always #5 clk = ~clk;

   gray_updn_counter #(.N(4), .SAT(1'b0)) dut0 (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
      .bin(bin0), .gray(gray0), .tc(tc0)
`ifdef GRAY_CHECK_EN
      , .err(err0)
`endif
   );

   gray_updn_counter #(.N(4), .SAT(1'b1)) dut1 (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
      .bin(bin1), .gray(gray1), .tc(tc1)
`ifdef GRAY_CHECK_EN
      , .err(err1)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; load = 1'b1; load_val = 4'h9; en = 1'b1;
      step();
      rst = 1'b0; load = 1'b0; en = 1'b0;
      n_checks++;
      if ({bin0, gray0, tc0} !== 9'h000) begin
         n_errors++;
         $display("FAIL reset: bin=%h gray=%h tc=%b, expected 0 0 0", bin0, gray0, tc0);
      end
`ifdef GRAY_CHECK_EN
      n_checks++;
      if (err0 !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_err: err=%b, expected 0", err0);
      end
`endif
   endtask

   task automatic test_wrap_up();
      logic [3:0] exp_g [16] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                                 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
      en = 1'b1; up = 1'b1;
      for (int i = 0; i < 16; i++) begin
         prev = gray0;
         step();
         n_checks++;
         if (bin0 !== 4'(i + 1) || gray0 !== exp_g[i] || tc0 !== (i == 15)) begin
            n_errors++;
            $display("FAIL wrap_up[%0d]: bin=%h gray=%h tc=%b, expected %h %h %b",
                     i, bin0, gray0, tc0, 4'(i + 1), exp_g[i], i == 15);
         end
         n_checks++;
         if ($countones(prev ^ gray0) != 1) begin
            n_errors++;
            $display("FAIL wrap_up_onebit[%0d]: gray %h -> %h, expected single-bit change", i, prev, gray0);
         end
      end
      en = 1'b0;
   endtask

   task automatic test_load_down();
      logic [3:0] exp_b [6] = '{4'h4, 4'h3, 4'h2, 4'h1, 4'h0, 4'hF};
      logic [3:0] exp_g [6] = '{4'h6, 4'h2, 4'h3, 4'h1, 4'h0, 4'h8};
      load = 1'b1; load_val = 4'h5; en = 1'b1; up = 1'b0;
      step();
      load = 1'b0;
      n_checks++;
      if (bin0 !== 4'h5 || gray0 !== 4'h7 || tc0 !== 1'b0) begin
         n_errors++;
         $display("FAIL load5: bin=%h gray=%h tc=%b, expected 5 7 0", bin0, gray0, tc0);
      end
      for (int i = 0; i < 6; i++) begin
         step();
         n_checks++;
         if (bin0 !== exp_b[i] || gray0 !== exp_g[i] || tc0 !== (i == 5)) begin
            n_errors++;
            $display("FAIL down[%0d]: bin=%h gray=%h tc=%b, expected %h %h %b",
                     i, bin0, gray0, tc0, exp_b[i], exp_g[i], i == 5);
         end
      end
      en = 1'b0;
   endtask

   task automatic test_sat();
      load = 1'b1; load_val = 4'hE; en = 1'b0;
      step();
      load = 1'b0; en = 1'b1; up = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         n_checks++;
         if (bin1 !== 4'hF || gray1 !== 4'h8 || tc1 !== (i != 0)) begin
            n_errors++;
            $display("FAIL sat_up[%0d]: bin=%h gray=%h tc=%b, expected f 8 %b", i, bin1, gray1, tc1, i != 0);
         end
      end
      load = 1'b1; load_val = 4'h1;
      step();
      load = 1'b0; up = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if (bin1 !== 4'h0 || gray1 !== 4'h0 || tc1 !== (i != 0)) begin
            n_errors++;
            $display("FAIL sat_down[%0d]: bin=%h gray=%h tc=%b, expected 0 0 %b", i, bin1, gray1, tc1, i != 0);
         end
      end
      en = 1'b0;
   endtask

   task automatic test_toggle();
      logic [3:0] exp_b [4] = '{4'h8, 4'h7, 4'h8, 4'h7};
      logic [3:0] exp_g [4] = '{4'hC, 4'h4, 4'hC, 4'h4};
      load = 1'b1; load_val = 4'h7;
      step();
      load = 1'b0; en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         up = (i % 2 == 0);
         prev = gray0;
         step();
         n_checks++;
         if (bin0 !== exp_b[i] || gray0 !== exp_g[i] || tc0 !== 1'b0 ||
             $countones(prev ^ gray0) != 1) begin
            n_errors++;
            $display("FAIL toggle[%0d]: bin=%h gray=%h tc=%b prev_gray=%h, expected %h %h 0 single-bit",
                     i, bin0, gray0, tc0, prev, exp_b[i], exp_g[i]);
         end
      end
      en = 1'b0;
   endtask

   task automatic test_rst_load_hold();
      en = 1'b1; up = 1'b1;
      step();
      step();
      rst = 1'b1; load = 1'b1; load_val = 4'h9;
      step();
      rst = 1'b0; load = 1'b0;
      n_checks++;
      if ({bin0, gray0, tc0} !== 9'h000) begin
         n_errors++;
         $display("FAIL rst_over_load: bin=%h gray=%h tc=%b, expected 0 0 0", bin0, gray0, tc0);
      end
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if ({bin0, gray0, tc0} !== 9'h000) begin
            n_errors++;
            $display("FAIL hold0[%0d]: bin=%h gray=%h tc=%b, expected 0 0 0", i, bin0, gray0, tc0);
         end
      end
      load = 1'b1; load_val = 4'hF;
      step();
      load = 1'b0; en = 1'b1; up = 1'b1;
      step();
      n_checks++;
      if (bin0 !== 4'h0 || tc0 !== 1'b1) begin
         n_errors++;
         $display("FAIL wrap_tc: bin=%h tc=%b, expected 0 1", bin0, tc0);
      end
      load = 1'b1; load_val = 4'hA; en = 1'b0;
      step();
      load = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if (bin0 !== 4'hA || gray0 !== 4'hF || tc0 !== 1'b0) begin
            n_errors++;
            $display("FAIL holdA[%0d]: bin=%h gray=%h tc=%b, expected a f 0", i, bin0, gray0, tc0);
         end
      end
   endtask

`ifdef GRAY_CHECK_EN
   task automatic test_checker();
      n_checks++;
      if (err0 !== 1'b0 || err1 !== 1'b0) begin
         n_errors++;
         $display("FAIL err_clean: err0=%b err1=%b, expected 0 0", err0, err1);
      end
      load = 1'b1; load_val = 4'h7; en = 1'b0;
      step();
      load = 1'b0;
      force dut0.r_bin = 4'h9;
      step();
      release dut0.r_bin;
      n_checks++;
      if (err0 !== 1'b1) begin
         n_errors++;
         $display("FAIL err_set: err=%b, expected 1", err0);
      end
      step();
      step();
      n_checks++;
      if (err0 !== 1'b1) begin
         n_errors++;
         $display("FAIL err_sticky: err=%b, expected 1", err0);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_checks++;
      if (err0 !== 1'b0 || bin0 !== 4'h0) begin
         n_errors++;
         $display("FAIL err_clear: err=%b bin=%h, expected 0 0", err0, bin0);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_wrap_up();
      test_load_down();
      test_sat();
      test_toggle();
      test_rst_load_hold();
`ifdef GRAY_CHECK_EN
      test_checker();
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/gray_updn_counter.md
# gray_updn_counter

Parametrised up/down Gray-code counter with enable, synchronous binary load, and wrap or saturate mode. Gray and binary count outputs are registered together, so both are valid and consistent in the same cycle. It also gives a one-cycle terminal-count pulse. It serves as the pointer/sequence generator for clock-domain-crossing logic and position counters throughout the design.

## Interface
- `N`, 4: counter width in bits, N >= 2; count range 0 .. 2^N-1
- `SAT`, 0: 0 = wrap modulo 2^N; 1 = saturate at bounds
- `clk`  input  1  rising-edge clock
- `rst`  input  1  synchronous, active-high reset
- `en`  input  1  count enable; one step per cycle while high
- `up`  input  1  direction: 1 = increment, 0 = decrement; sampled only when counting
- `load`  input  1  synchronous load strobe
- `load_val`  input  N  binary value to load
- `bin`  output  N  registered binary count
- `gray`  output  N  registered Gray count; always equals bin ^ (bin >> 1)
- `tc`  output  1  registered terminal-count pulse
- `err`  output  1  sticky checker flag; present only with GRAY_CHECK_EN

## Operation
- Priority per cycle: `rst` > `load` > `en` > hold.
- `rst`: bin = 0, gray = 0, tc = 0, err = 0.
- `load`: bin = load_val, gray = bin2gray(load_val), tc = 0; `en` and `up` are ignored.
- Count, `en`=1, `up`=1:
  - bin = bin + 1, truncated to N bits.
  - At bin = 2^N-1: wraps to 0 when SAT=0; holds when SAT=1.
- Count, `en`=1, `up`=0:
  - bin = bin - 1.
  - At bin = 0: wraps to 2^N-1 when SAT=0; holds when SAT=1.
- Hold, `en`=0: all registers keep their value; tc = 0.
- The next gray value is computed from the next bin value and registered in the same edge. There is no extra pipeline lag between bin and gray.
- tc is 1 for exactly one cycle, registered in the same edge as the bin update, when a counting step starts from a bound:
  - `up`=1 and bin = 2^N-1, or
  - `up`=0 and bin = 0.
  - This applies in both SAT modes: in SAT=1, tc pulses on every attempted step past the bound.
- Direction change between consecutive cycles is allowed with no dead cycle.
- Reset asserted mid-count takes effect at the next edge, regardless of `load` or `en`.

## Timing
- Latency from `en`/`load` sampled at edge k to the new bin, gray and tc: visible after edge k (1 cycle).
- Outputs are driven directly from flops, with no combinational path from inputs to outputs.
- Consecutive gray values differ in exactly one bit per counting step. Zero bits change on hold or saturation. Arbitrary change is allowed only on load or reset.

## Configuration
- `GRAY_CHECK_EN` defined:
  - Port `err` exists, and a checker instance is compiled in.
  - The checker keeps the previous gray value and a flag marking that the previous edge was a load or reset.
  - err is set one cycle after either violation:
    - gray2bin(gray) != bin, or
    - the Hamming distance between consecutive gray values is > 1 with no preceding load or reset.
  - err is sticky until `rst`.
- Not defined: no `err` port and no checker logic; counter behaviour is identical.

## Structure
- Package `gray_pkg` holds:
  - functions `bin2gray` and `gray2bin`, both width-generic via a parameterised width constant;
  - localparam helpers for the max count (2^N-1).
- Sub-module `gray_checker` (parameter N) implements the GRAY_CHECK_EN logic and is instantiated only under the macro.

## Test plan
- Reset, then N=4, SAT=0, en=1, up=1 for 17 cycles -> gray sequence 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0; tc=1 only on the cycle bin goes F->0.
- load=1, load_val=5 with en=1, up=0 -> bin=5, gray=7, tc=0; next cycles give bin 4,3,2,1,0,F, with tc pulsing on 0->F.
- SAT=1, load 14, up=1 for 4 cycles -> bin 15,15,15,15; tc=1 on cycles 2-4; gray holds 8.
- Toggle `up` every cycle from bin=7 with en=1 -> bin 8,7,8,7 and gray C,4,C,4; every gray transition is single-bit.
- rst asserted in the same cycle as load=1 mid-count -> all outputs 0 after the edge; then en=0 for 3 cycles -> outputs hold.
- GRAY_CHECK_EN, force the bin flop to 9 while gray holds 4 -> err=1 one cycle later and stays 1 until rst; a normal run of 40 cycles with loads -> err stays 0.
